// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: single-clock elastic buffer between the video-decode path and
// the VGA controller. It stores {SOF, R, G, B} words and returns one pixel per
// controller request, locked to the controller's frame via the first-pop SOF check.
//
// state  | meaning
// ALIGN  | waiting for an SOF word; everything else is discarded
// PRIME  | filling; leaves on a VS falling edge once FILL_LEVEL words are held
// STREAM | one pop per request; a misaligned frame start or an empty pop flushes to ALIGN
module vga_pixel_fifo #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int FILL_LEVEL = 640
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [9:0]        iR,
  input  logic [9:0]        iG,
  input  logic [9:0]        iB,
  output logic              oREADY,
  input  logic              iRequest,
  input  logic              iVGA_VS,
  output logic [9:0]        oRed,
  output logic [9:0]        oGreen,
  output logic [9:0]        oBlue,
  output logic [ADDR_W:0]   oLevel,
  output logic              oUnderflow,
  output logic              oOverflow,
  output logic              oStreaming
);

  localparam logic [ADDR_W:0] DepthL = DEPTH;
  localparam logic [ADDR_W:0] FillL  = FILL_LEVEL;

  typedef enum logic [1:0] {ALIGN, PRIME, STREAM} state_t;

  state_t              state, nextState;
  logic [30:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   wrPtr, rdPtr;
  logic [ADDR_W:0]     level;
  logic [30:0]         rdWord;
  logic                vsPrev, vsFall, firstPending;
  logic                full, empty;
  logic                push, pop, flush, showPixel, setUnder, setOver;

  assign full       = (level == DepthL);
  assign empty      = (level == '0);
  assign oREADY     = !full;
  assign oLevel     = level;
  assign oStreaming = (state == STREAM);
  assign vsFall     = vsPrev & ~iVGA_VS;
  assign rdWord     = mem[rdPtr];

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= ALIGN;
    else      state <= nextState;
  end

  // Next-state and per-cycle FIFO control. Space is judged on the level at
  // cycle start, so a same-cycle pop never makes room for a write, and an
  // empty FIFO never forwards a same-cycle write to the reader.
  always_comb begin
    nextState = state;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    showPixel = 1'b0;
    setUnder  = 1'b0;
    setOver   = 1'b0;
    case (state)
      ALIGN: begin
        if (iDVAL && iSOF && !full) begin
          push      = 1'b1;
          nextState = PRIME;
        end
      end
      PRIME: begin
        if (iDVAL) begin
          if (full) setOver = 1'b1;
          else      push    = 1'b1;
        end
        if (vsFall && (level >= FillL)) nextState = STREAM;
      end
      STREAM: begin
        if (iDVAL) begin
          if (full) setOver = 1'b1;
          else      push    = 1'b1;
        end
        if (iRequest) begin
          if (empty) begin
            setUnder = 1'b1;
            flush    = 1'b1;
          end else if ((vsFall || firstPending) && !rdWord[30]) begin
            flush = 1'b1;
          end else begin
            pop       = 1'b1;
            showPixel = 1'b1;
          end
        end
        if (flush) begin
          push      = 1'b0;
          nextState = ALIGN;
        end
      end
      default: nextState = ALIGN;
    endcase
  end

  // Storage write; content is not reset, the pointers define validity.
  always_ff @(posedge iCLK) begin
    if (push) mem[wrPtr] <= {iSOF, iR, iG, iB};
  end

  // Pointers, level, frame-start tracking, sticky flags and registered pixel.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      level        <= '0;
      vsPrev       <= 1'b1;
      firstPending <= 1'b0;
      oUnderflow   <= 1'b0;
      oOverflow    <= 1'b0;
      oRed         <= '0;
      oGreen       <= '0;
      oBlue        <= '0;
    end else begin
      vsPrev <= iVGA_VS;
      if (setUnder) oUnderflow <= 1'b1;
      if (setOver)  oOverflow  <= 1'b1;
      if (showPixel) {oRed, oGreen, oBlue} <= rdWord[29:0];
      else           {oRed, oGreen, oBlue} <= '0;
      if (flush) begin
        wrPtr        <= '0;
        rdPtr        <= '0;
        level        <= '0;
        firstPending <= 1'b0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
        // The pop in a vs_fall cycle is itself the frame's first pop.
        if (pop)         firstPending <= 1'b0;
        else if (vsFall) firstPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Directed bench for vga_pixel_fifo: vector table for reset/alignment, then
// hand-written sequences for streaming, underflow, full, simultaneous and misalign.
module tb_vga_pixel_fifo;

  logic        iCLK = 1'b0;
  logic        iRST, iDVAL, iSOF, iRequest, iVGA_VS;
  logic [9:0]  iR, iG, iB;
  logic        oREADY, oUnderflow, oOverflow, oStreaming;
  logic [9:0]  oRed, oGreen, oBlue;
  logic [10:0] oLevel;

  int checks   = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  vga_pixel_fifo dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF),
    .iR(iR), .iG(iG), .iB(iB), .oREADY(oREADY),
    .iRequest(iRequest), .iVGA_VS(iVGA_VS),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oLevel(oLevel),
    .oUnderflow(oUnderflow), .oOverflow(oOverflow), .oStreaming(oStreaming)
  );

  typedef struct {
    logic       dval;
    logic       sof;
    logic [9:0] r;
    logic       req;
    int         expLevel;
    int         expRed;
    logic       expStream;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic dval, input logic sof, input logic [9:0] r,
                       input logic req, input logic vs);
    iDVAL    = dval;
    iSOF     = sof;
    iR       = r;
    iG       = r ^ 10'h155;
    iB       = ~r;
    iRequest = req;
    iVGA_VS  = vs;
  endtask

  task automatic step;
    @(posedge iCLK);
    #1;
  endtask

  task automatic doReset;
    iRST = 1'b1;
    drive(0, 0, 0, 0, 1);
    step();
    step();
    iRST = 1'b0;
  endtask

  initial begin
    // 1: reset
    doReset();
    check("rst_level", oLevel, 0);
    check("rst_ready", oREADY, 1);
    check("rst_red", oRed, 0);
    check("rst_stream", oStreaming, 0);
    check("rst_under", oUnderflow, 0);
    check("rst_over", oOverflow, 0);

    // 2: alignment table -- 5 non-SOF drops, SOF word accepted, PRIME ignores requests
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 1'b0, 10'(i + 7), 1'b0, 0, 0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 10'd0, 1'b0, 1, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 10'd0, 1'b0, 1, 0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 10'd0, 1'b1, 1, 0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].dval, vecs[i].sof, vecs[i].r, vecs[i].req, 1'b1);
      step();
      check($sformatf("vec%0d_level", i), oLevel, vecs[i].expLevel);
      check($sformatf("vec%0d_red", i), oRed, vecs[i].expRed);
      check($sformatf("vec%0d_stream", i), oStreaming, vecs[i].expStream);
    end

    // 2: rest of the frame, vs_fall, then 640 requests
    for (int i = 1; i < 640; i++) begin
      drive(1, 0, 10'(i), 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 1);
    check("prime_level", oLevel, 640);
    drive(0, 0, 0, 0, 0);
    step();
    check("vsfall_stream", oStreaming, 1);
    for (int i = 0; i < 640; i++) begin
      drive(0, 0, 0, 1, 1);
      step();
      check($sformatf("frame_red%0d", i), oRed, i);
      if (i == 5) check("frame_green5", oGreen, 5 ^ 10'h155);
    end
    drive(0, 0, 0, 0, 1);
    step();
    check("after_frame_red", oRed, 0);
    check("after_frame_level", oLevel, 0);
    check("after_frame_under", oUnderflow, 0);

    // 3: underflow with level 3
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 10'(100 + i), 0, 1);
      step();
    end
    check("uf_level3", oLevel, 3);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1);
      step();
      check($sformatf("uf_red%0d", i), oRed, (i < 3) ? 100 + i : 0);
    end
    check("uf_flag", oUnderflow, 1);
    check("uf_stream", oStreaming, 0);
    check("uf_level", oLevel, 0);

    // 4: full -- 1030 writes, last 6 dropped
    doReset();
    for (int i = 0; i < 1030; i++) begin
      drive(1, i == 0, 10'(1023 - i), 0, 1);
      step();
    end
    check("full_level", oLevel, 1024);
    check("full_ready", oREADY, 0);
    check("full_over", oOverflow, 1);
    drive(0, 0, 0, 0, 0);
    step();
    check("full_stream", oStreaming, 1);
    // write while full with a same-cycle pop: write dropped, level drops by one
    drive(1, 0, 10'd555, 1, 1);
    step();
    check("full_pop0_red", oRed, 1023);
    check("full_pop0_level", oLevel, 1023);
    check("full_pop0_stream", oStreaming, 1);
    for (int k = 1; k < 924; k++) begin
      drive(0, 0, 0, 1, 1);
      step();
      check($sformatf("full_red%0d", k), oRed, 1023 - k);
    end
    check("sim_start_level", oLevel, 100);

    // 5: simultaneous write + request at level 100
    for (int j = 0; j < 50; j++) begin
      drive(1, 0, 10'(500 + j), 1, 1);
      step();
      check($sformatf("sim_red%0d", j), oRed, 99 - j);
      check($sformatf("sim_level%0d", j), oLevel, 100);
    end
    for (int k = 0; k < 100; k++) begin
      drive(0, 0, 0, 1, 1);
      step();
      check($sformatf("drain_red%0d", k), oRed, (k < 50) ? 49 - k : 500 + k - 50);
    end
    drive(0, 0, 0, 0, 1);
    step();
    check("drain_level", oLevel, 0);
    check("drain_red_idle", oRed, 0);
    check("drain_under", oUnderflow, 0);

    // 6: misaligned second frame, with a write in the flush cycle
    doReset();
    for (int i = 0; i < 640; i++) begin
      drive(1, i == 0, 10'(i + 1), 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 640; i++) begin
      drive(0, 0, 0, 1, 1);
      step();
      check($sformatf("f1_red%0d", i), oRed, i + 1);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 10'd5, 0, 1);
      step();
    end
    check("mis_level10", oLevel, 10);
    drive(1, 0, 10'd9, 1, 0);
    step();
    check("mis_red", oRed, 0);
    check("mis_green", oGreen, 0);
    check("mis_level", oLevel, 0);
    check("mis_stream", oStreaming, 0);

    // 6: reset in the middle of STREAM
    for (int i = 0; i < 640; i++) begin
      drive(1, i == 0, 10'(i + 1), 0, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 1);
      step();
      check($sformatf("f2_red%0d", i), oRed, i + 1);
    end
    iRST = 1'b1;
    drive(0, 0, 0, 1, 1);
    step();
    check("midrst_red", oRed, 0);
    check("midrst_level", oLevel, 0);
    check("midrst_stream", oStreaming, 0);
    check("midrst_ready", oREADY, 1);
    iRST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
